// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a single-port memory: the CPU path and the program loader.
// Round-robin on ties, loader lock, fixed access latency, one-cycle ACK and registered read data.
module mem_bus_arbiter #(
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int MEM_LAT = 2
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  output logic          CPU_ACK,
  output logic [DW-1:0] CPU_RDATA,
  input  logic          LDR_REQ,
  input  logic          LDR_WE,
  input  logic [AW-1:0] LDR_ADDR,
  input  logic [DW-1:0] LDR_WDATA,
  input  logic          LDR_LOCK,
  output logic          LDR_ACK,
  output logic [DW-1:0] LDR_RDATA,
  output logic          MEM_EN,
  output logic          RORW,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          BUSY,
  output logic          OWNER
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            last_owner_q, last_owner_d;
  logic            owner_q, owner_d;
  logic            mem_en_q, mem_en_d;
  logic            rorw_q, rorw_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            busy_q, busy_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic            ldr_ack_q, ldr_ack_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   ldr_rdata_q, ldr_rdata_d;
  logic            cpu_v_s;
  logic            grant_ldr_s;

  // Request qualification and winner selection (lock masks the CPU, ties go to the non-last owner)
  always_comb begin
    cpu_v_s = CPU_REQ & ~LDR_LOCK;
    if (cpu_v_s && LDR_REQ) begin
      grant_ldr_s = ~last_owner_q;
    end else if (LDR_REQ) begin
      grant_ldr_s = 1'b1;
    end else begin
      grant_ldr_s = 1'b0;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    mem_en_d     = mem_en_q;
    rorw_d       = rorw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    busy_d       = busy_q;
    cpu_ack_d    = 1'b0;
    ldr_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_v_s || LDR_REQ) begin
          owner_d  = grant_ldr_s;
          mem_en_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = ST_ACCESS;
          if (grant_ldr_s) begin
            rorw_d      = LDR_WE;
            mem_addr_d  = LDR_ADDR;
            mem_wdata_d = LDR_WDATA;
          end else begin
            rorw_d      = CPU_WE;
            mem_addr_d  = CPU_ADDR;
            mem_wdata_d = CPU_WDATA;
          end
        end else begin
          mem_en_d = 1'b0;
          busy_d   = 1'b0;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Read data is only valid on the last access cycle, so capture it here
          if (!rorw_q) begin
            if (owner_q) begin
              ldr_rdata_d = MEM_RDATA;
            end else begin
              cpu_rdata_d = MEM_RDATA;
            end
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
          if (owner_q) begin
            ldr_ack_d = 1'b1;
          end else begin
            cpu_ack_d = 1'b1;
          end
          mem_en_d = 1'b0;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        last_owner_d = owner_q;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end

      default: begin
        mem_en_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; last_owner resets to the loader so the CPU wins the first tie
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      rorw_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      cpu_ack_q    <= 1'b0;
      ldr_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      mem_en_q     <= mem_en_d;
      rorw_q       <= rorw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      cpu_ack_q    <= cpu_ack_d;
      ldr_ack_q    <= ldr_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  assign CPU_ACK   = cpu_ack_q;
  assign LDR_ACK   = ldr_ack_q;
  assign CPU_RDATA = cpu_rdata_q;
  assign LDR_RDATA = ldr_rdata_q;
  assign MEM_EN    = mem_en_q;
  assign RORW      = rorw_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign BUSY      = busy_q;
  assign OWNER     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-phase reference model.
module tb_mem_bus_arbiter;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic          CLK;
  logic          RESET_N;
  logic          CPU_REQ, CPU_WE, CPU_ACK;
  logic [AW-1:0] CPU_ADDR;
  logic [DW-1:0] CPU_WDATA, CPU_RDATA;
  logic          LDR_REQ, LDR_WE, LDR_LOCK, LDR_ACK;
  logic [AW-1:0] LDR_ADDR;
  logic [DW-1:0] LDR_WDATA, LDR_RDATA;
  logic          MEM_EN, RORW, BUSY, OWNER;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA, MEM_RDATA;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
    .LDR_REQ(LDR_REQ), .LDR_WE(LDR_WE), .LDR_ADDR(LDR_ADDR), .LDR_WDATA(LDR_WDATA),
    .LDR_LOCK(LDR_LOCK), .LDR_ACK(LDR_ACK), .LDR_RDATA(LDR_RDATA),
    .MEM_EN(MEM_EN), .RORW(RORW), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .BUSY(BUSY), .OWNER(OWNER)
  );

  initial CLK = 1'b0;
  always #100 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: m_k is the cycle index inside the current transaction (0 = idle)
  int            m_k;
  logic          m_owner, m_last, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata [2];

  logic c_pend, l_pend;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k       = 0;
    m_owner   = 1'b0;
    m_last    = 1'b1;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
  endtask

  // Advance the model across one rising edge using the currently driven inputs
  task automatic model_next();
    logic cpu_v;
    if (m_k == 0) begin
      cpu_v = CPU_REQ && !LDR_LOCK;
      if (cpu_v || LDR_REQ) begin
        m_owner = (cpu_v && LDR_REQ) ? !m_last : LDR_REQ;
        m_we    = m_owner ? LDR_WE    : CPU_WE;
        m_addr  = m_owner ? LDR_ADDR  : CPU_ADDR;
        m_wdata = m_owner ? LDR_WDATA : CPU_WDATA;
        m_k     = 1;
      end
    end else if (m_k == LAT) begin
      if (!m_we) m_rdata[m_owner] = MEM_RDATA;
      m_k = LAT + 1;
    end else if (m_k == LAT + 1) begin
      m_last = m_owner;
      m_k    = 0;
    end else begin
      m_k = m_k + 1;
    end
  endtask

  task automatic check_outputs(input string ph);
    logic e_en, e_ack_c, e_ack_l;
    e_en    = (m_k >= 1) && (m_k <= LAT);
    e_ack_c = (m_k == LAT + 1) && !m_owner;
    e_ack_l = (m_k == LAT + 1) &&  m_owner;
    check_eq({ph, "_mem_en"},    32'(MEM_EN),    32'(e_en));
    check_eq({ph, "_busy"},      32'(BUSY),      32'(m_k != 0));
    check_eq({ph, "_owner"},     32'(OWNER),     32'(m_owner));
    check_eq({ph, "_rorw"},      32'(RORW),      32'(m_we));
    check_eq({ph, "_mem_addr"},  32'(MEM_ADDR),  32'(m_addr));
    check_eq({ph, "_mem_wdata"}, 32'(MEM_WDATA), 32'(m_wdata));
    check_eq({ph, "_cpu_ack"},   32'(CPU_ACK),   32'(e_ack_c));
    check_eq({ph, "_ldr_ack"},   32'(LDR_ACK),   32'(e_ack_l));
    check_eq({ph, "_cpu_rdata"}, 32'(CPU_RDATA), 32'(m_rdata[0]));
    check_eq({ph, "_ldr_rdata"}, 32'(LDR_RDATA), 32'(m_rdata[1]));
    check_eq({ph, "_ack_excl"},  32'(CPU_ACK & LDR_ACK), 32'd0);
  endtask

  task automatic tick(input string ph);
    model_next();
    @(negedge CLK);
    check_outputs(ph);
  endtask

  // Random requester behaviour: hold REQ until ACK, scramble fields after grant, sometimes drop early
  task automatic random_drive();
    logic ack_c, ack_l, busy_c, busy_l;
    ack_c  = (m_k == LAT + 1) && !m_owner;
    ack_l  = (m_k == LAT + 1) &&  m_owner;
    busy_c = (m_k != 0) && !m_owner;
    busy_l = (m_k != 0) &&  m_owner;
    if (c_pend && ack_c) begin
      c_pend = 1'b0; CPU_REQ = 1'b0;
    end else if (!c_pend && ($urandom_range(2) == 0)) begin
      c_pend = 1'b1; CPU_REQ = 1'b1; CPU_WE = 1'($urandom);
      CPU_ADDR = 4'($urandom); CPU_WDATA = 8'($urandom);
    end else if (busy_c) begin
      CPU_WE = 1'($urandom); CPU_ADDR = 4'($urandom); CPU_WDATA = 8'($urandom);
      if ($urandom_range(7) == 0) CPU_REQ = 1'b0;
    end
    if (l_pend && ack_l) begin
      l_pend = 1'b0; LDR_REQ = 1'b0;
    end else if (!l_pend && ($urandom_range(2) == 0)) begin
      l_pend = 1'b1; LDR_REQ = 1'b1; LDR_WE = 1'($urandom);
      LDR_ADDR = 4'($urandom); LDR_WDATA = 8'($urandom);
    end else if (busy_l) begin
      LDR_WE = 1'($urandom); LDR_ADDR = 4'($urandom); LDR_WDATA = 8'($urandom);
      if ($urandom_range(7) == 0) LDR_REQ = 1'b0;
    end
    if ($urandom_range(19) == 0) LDR_LOCK = !LDR_LOCK;
    MEM_RDATA = 8'($urandom);
  endtask

  logic ack_who [$];
  int   ack_at  [$];

  initial begin
    RESET_N = 1'b1;
    CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;
    LDR_REQ = 1'b0; LDR_WE = 1'b0; LDR_ADDR = '0; LDR_WDATA = '0; LDR_LOCK = 1'b0;
    MEM_RDATA = '0;
    c_pend = 1'b0; l_pend = 1'b0;
    model_reset();

    // 1: reset, then idle with no requests
    #85 RESET_N = 1'b0;
    #1 check_outputs("rst");
    #199 RESET_N = 1'b1;
    tick("idle"); tick("idle");
    check_eq("idle_no_en", 32'(MEM_EN), 32'd0);

    // 2: CPU read
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 4'h3; MEM_RDATA = 8'hA5;
    tick("t2");
    check_eq("t2_en", 32'(MEM_EN), 32'd1);
    check_eq("t2_addr", 32'(MEM_ADDR), 32'h3);
    check_eq("t2_rorw", 32'(RORW), 32'd0);
    tick("t2");
    check_eq("t2_en2", 32'(MEM_EN), 32'd1);
    tick("t2");
    check_eq("t2_ack", 32'(CPU_ACK), 32'd1);
    check_eq("t2_rdata", 32'(CPU_RDATA), 32'hA5);
    CPU_REQ = 1'b0;
    tick("t2");

    // 3: loader write
    LDR_REQ = 1'b1; LDR_WE = 1'b1; LDR_ADDR = 4'hF; LDR_WDATA = 8'h5A; MEM_RDATA = 8'h77;
    tick("t3");
    check_eq("t3_rorw", 32'(RORW), 32'd1);
    check_eq("t3_wdata", 32'(MEM_WDATA), 32'h5A);
    check_eq("t3_owner", 32'(OWNER), 32'd1);
    tick("t3"); tick("t3");
    check_eq("t3_ack", 32'(LDR_ACK), 32'd1);
    check_eq("t3_rdata", 32'(LDR_RDATA), 32'h00);
    LDR_REQ = 1'b0;
    tick("t3");

    // 4: both requesting continuously -> strict alternation, one ACK per 4 cycles
    CPU_REQ = 1'b1; CPU_WE = 1'b0; LDR_REQ = 1'b1; LDR_WE = 1'b0;
    for (int t = 0; t < 15; t++) begin
      MEM_RDATA = 8'($urandom);
      tick("t4");
      if (CPU_ACK) begin ack_who.push_back(1'b0); ack_at.push_back(t); end
      if (LDR_ACK) begin ack_who.push_back(1'b1); ack_at.push_back(t); end
    end
    CPU_REQ = 1'b0; LDR_REQ = 1'b0;
    tick("t4");
    check_eq("t4_nacks", 32'(ack_who.size()), 32'd4);
    for (int i = 0; i < ack_who.size(); i++) begin
      check_eq("t4_order", 32'(ack_who[i]), 32'(i % 2));
      check_eq("t4_spacing", 32'(ack_at[i]), 32'(4 * i + 2));
    end

    // 5: lock -> only the loader is served; unlocking hands the next grant to the CPU
    ack_who.delete();
    LDR_LOCK = 1'b1; CPU_REQ = 1'b1; LDR_REQ = 1'b1;
    for (int t = 0; t < 11; t++) begin
      tick("t5");
      if (CPU_ACK) ack_who.push_back(1'b0);
      if (LDR_ACK) ack_who.push_back(1'b1);
    end
    check_eq("t5_nacks", 32'(ack_who.size()), 32'd3);
    for (int i = 0; i < ack_who.size(); i++) check_eq("t5_only_ldr", 32'(ack_who[i]), 32'd1);
    LDR_LOCK = 1'b0;
    tick("t5"); tick("t5");
    check_eq("t5_cpu_next", 32'(OWNER), 32'd0);
    check_eq("t5_cpu_en", 32'(MEM_EN), 32'd1);
    LDR_REQ = 1'b0;
    tick("t5"); tick("t5");
    check_eq("t5_cpu_ack", 32'(CPU_ACK), 32'd1);
    CPU_REQ = 1'b0;
    tick("t5");

    // 6: reset during the second access cycle of a CPU read
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 4'($urandom);
    tick("t6"); tick("t6");
    RESET_N = 1'b0;
    #1;
    check_eq("t6_en_clr", 32'(MEM_EN), 32'd0);
    check_eq("t6_busy_clr", 32'(BUSY), 32'd0);
    model_reset();
    check_outputs("t6rst");
    CPU_REQ = 1'b0;
    #50 RESET_N = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick("t6post");
      check_eq("t6_no_ack", 32'(CPU_ACK), 32'd0);
    end

    // Random traffic
    for (int t = 0; t < 1500; t++) begin
      random_drive();
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
